// File: rtl/pp_column_reducer.sv
// Pipelined Dadda column reducer plus final CPA, elastic valid/ready stages.
// Define PP_REDUCER_CPA_SPLIT_EN to split the CPA into two registered halves.

module pp_dadda_step #(
    parameter int NCOL = 16,
    parameter int HI   = 6,
    parameter int HO   = 4
) (
    input  logic [NCOL-1:0][HI-1:0] din,
    output logic [NCOL-1:0][HO-1:0] dout
);
    logic [HI-1:0] cv;
    logic [HI-1:0] nv;
    int cn, nn, e, f, a, k;

    // Greedy FA/HA per column; carries feed column c+1, top-column carries drop.
    always_comb begin
        dout = '0;
        cv = '0;
        nv = '0;
        cn = 0;
        nn = 0;
        e = 0;
        f = 0;
        a = 0;
        k = 0;
        for (int c = 0; c < NCOL; c++) begin
            e = HI + cn - HO;
            if (e < 0) e = 0;
            f = e / 2;
            a = e % 2;
            nv = '0;
            nn = 0;
            k = 0;
            for (int i = 0; i < HI / 3; i++) begin
                if (i < f) begin
                    dout[c][k] = din[c][3*i] ^ din[c][3*i+1] ^ din[c][3*i+2];
                    nv[nn] = (din[c][3*i] & din[c][3*i+1]) |
                             (din[c][3*i+2] & (din[c][3*i] ^ din[c][3*i+1]));
                    k++;
                    nn++;
                end
            end
            if (a == 1) begin
                dout[c][k] = din[c][3*f] ^ din[c][3*f+1];
                nv[nn] = din[c][3*f] & din[c][3*f+1];
                k++;
                nn++;
            end
            for (int i = 0; i < HI; i++) begin
                if (i >= 3*f + 2*a) begin
                    dout[c][k] = din[c][i];
                    k++;
                end
            end
            for (int i = 0; i < HI; i++) begin
                if (i < cn) begin
                    dout[c][k] = cv[i];
                    k++;
                end
            end
            cv = nv;
            cn = nn;
        end
    end
endmodule

module pp_column_reducer #(
    parameter int BITWIDTH = 8,
    parameter int OUT_LSB  = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*BITWIDTH-1:0][BITWIDTH/2+1:0] in_cols,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [2*BITWIDTH-OUT_LSB-1:0]         product
);
    localparam int NCOL = 2 * BITWIDTH;
    localparam int H    = BITWIDTH / 2 + 2;

    function automatic int dnext(input int h);
        int d;
        d = 2;
        while ((d * 3) / 2 < h) d = (d * 3) / 2;
        return d;
    endfunction

    function automatic int hstage(input int n);
        int h;
        h = H;
        for (int i = 0; i < n; i++) h = dnext(h);
        return h;
    endfunction

    function automatic int nred(input int h0);
        int h;
        int n;
        h = h0;
        n = 0;
        while (h > 2) begin
            h = dnext(h);
            n++;
        end
        return n;
    endfunction

    localparam int NRED = nred(H);
`ifdef PP_REDUCER_CPA_SPLIT_EN
    localparam int NS = NRED + 2;
`else
    localparam int NS = NRED + 1;
`endif

    logic [NS:1]   vld;
    logic [NS+1:1] rdy;
    logic          live;

    assign rdy[NS+1]  = out_ready;
    assign in_ready   = live && rdy[1];
    assign out_valid  = vld[NS];

    for (genvar k = 1; k <= NS; k++) begin : g_rdy
        assign rdy[k] = !vld[k] || rdy[k+1];
    end

    // Input acceptance opens only from the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
            vld  <= '0;
        end else begin
            live <= 1'b1;
            if (rdy[1]) vld[1] <= in_valid && in_ready;
            for (int k = 2; k <= NS; k++) begin
                if (rdy[k]) vld[k] <= vld[k-1];
            end
        end
    end

    for (genvar k = 1; k <= NRED; k++) begin : g_red
        localparam int HI = hstage(k - 1);
        localparam int HO = hstage(k);
        logic [NCOL-1:0][HI-1:0] d;
        logic [NCOL-1:0][HO-1:0] n;
        logic [NCOL-1:0][HO-1:0] q;
        logic                    ld;

        if (k == 1) begin : g_src
            assign d  = in_cols;
            assign ld = in_valid && in_ready;
        end else begin : g_src
            assign d  = g_red[k-1].q;
            assign ld = rdy[k] && vld[k-1];
        end

        pp_dadda_step #(
            .NCOL (NCOL),
            .HI   (HI),
            .HO   (HO)
        ) u_step (
            .din  (d),
            .dout (n)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else if (ld) q <= n;
        end
    end

    logic [NCOL-1:0] r0;
    logic [NCOL-1:0] r1;
    logic [NCOL-1:0] sum;

    always_comb begin
        r0 = '0;
        r1 = '0;
        for (int c = 0; c < NCOL; c++) begin
            r0[c] = g_red[NRED].q[c][0];
            r1[c] = g_red[NRED].q[c][1];
        end
    end

`ifdef PP_REDUCER_CPA_SPLIT_EN
    localparam int HB = BITWIDTH;
    logic [HB:0]        lo;
    logic [HB-1:0]      alo;
    logic               acy;
    logic [NCOL-HB-1:0] ah0;
    logic [NCOL-HB-1:0] ah1;
    logic [NCOL-HB-1:0] acx;

    assign lo  = {1'b0, r0[HB-1:0]} + {1'b0, r1[HB-1:0]};
    assign acx = {{(NCOL-HB-1){1'b0}}, acy};
    assign sum = {ah0 + ah1 + acx, alo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alo <= '0;
            acy <= 1'b0;
            ah0 <= '0;
            ah1 <= '0;
        end else if (rdy[NS-1] && vld[NS-2]) begin
            {acy, alo} <= lo;
            ah0 <= r0[NCOL-1:HB];
            ah1 <= r1[NCOL-1:HB];
        end
    end
`else
    assign sum = r0 + r1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) product <= '0;
        else if (rdy[NS] && vld[NS-1]) product <= sum[NCOL-1:OUT_LSB];
    end
endmodule

// File: tb/tb_pp_column_reducer.sv
// Self-checking bench for pp_column_reducer: directed pyramids, random
// streams with stalls, back-to-back throughput and mid-stream reset.
module tb_pp_column_reducer;
    localparam int BW = 8;
    localparam int NC = 2 * BW;
    localparam int H  = BW / 2 + 2;
`ifdef PP_REDUCER_CPA_SPLIT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_ready8;
    logic [NC-1:0][H-1:0] in_cols;
    logic                 out_valid;
    logic                 out_valid8;
    logic                 out_ready;
    logic [15:0]          product;
    logic [7:0]           product8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pp_column_reducer #(.BITWIDTH(BW), .OUT_LSB(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cols   (in_cols),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    pp_column_reducer #(.BITWIDTH(BW), .OUT_LSB(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_cols   (in_cols),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .product   (product8)
    );

    // Reference: every set bit contributes 2^col, result modulo 2^16.
    function automatic logic [15:0] ref_sum(input logic [NC-1:0][H-1:0] c);
        int unsigned s;
        s = 0;
        for (int col = 0; col < NC; col++)
            for (int row = 0; row < H; row++)
                if (c[col][row]) s += (32'd1 << col);
        return s[15:0];
    endfunction

    function automatic logic [NC-1:0][H-1:0] rand_cols();
        logic [NC-1:0][H-1:0] c;
        logic [31:0] r;
        for (int col = 0; col < NC; col++) begin
            r = $urandom;
            c[col] = r[H-1:0];
        end
        return c;
    endfunction

    task automatic send_one(input logic [NC-1:0][H-1:0] cols, output int lat,
                            output logic [15:0] p, output logic [7:0] p8);
        bit done;
        lat = -1;
        p = 'x;
        p8 = 'x;
        done = 0;
        @(negedge clk);
        in_cols = cols;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        if (!in_ready) begin
            in_valid = 1'b0;
        end else begin
            for (int n = 1; n <= 20 && !done; n++) begin
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                in_cols = 'x;
                if (out_valid) begin
                    lat = n;
                    p = product;
                    p8 = product8;
                    done = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_cols = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        if (in_ready !== 1'b0) errors++;
        checks++;
        if (out_valid !== 1'b0 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid, out_valid8);
        end
        checks++;
        if (product !== 16'h0 || product8 !== 8'h0) begin
            errors++;
            $display("FAIL reset_product: got %h/%h expected 0", product, product8);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b/%b expected 1", in_ready, in_ready8);
        end
    endtask

    task automatic test_directed();
        logic [NC-1:0][H-1:0] c;
        logic [15:0] p;
        logic [7:0] p8;
        int lat;
        c = '0;
        send_one(c, lat, p, p8);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL zero_product: got %h expected 0000", p);
        end
        c = '0;
        c[3][0] = 1'b1;
        send_one(c, lat, p, p8);
        checks++;
        if (p !== 16'h0008) begin
            errors++;
            $display("FAIL col3_product: got %h expected 0008", p);
        end
        c = '0;
        c[15][0] = 1'b1;
        send_one(c, lat, p, p8);
        checks++;
        if (p !== 16'h8000) begin
            errors++;
            $display("FAIL col15_product: got %h expected 8000", p);
        end
        c = '1;
        send_one(c, lat, p, p8);
        checks++;
        if (p !== 16'hFFFA) begin
            errors++;
            $display("FAIL all_ones_product: got %h expected fffa", p);
        end
        checks++;
        if (p8 !== 8'hFF) begin
            errors++;
            $display("FAIL all_ones_upper: got %h expected ff", p8);
        end
        c = '0;
        c[7] = '1;
        send_one(c, lat, p, p8);
        checks++;
        if (p !== 16'h0300) begin
            errors++;
            $display("FAIL col7_product: got %h expected 0300", p);
        end
        checks++;
        if (p8 !== 8'h03) begin
            errors++;
            $display("FAIL col7_upper: got %h expected 03", p8);
        end
    endtask

    task automatic test_random();
        logic [NC-1:0][H-1:0] c;
        logic [15:0] p;
        logic [15:0] e;
        logic [7:0] p8;
        int lat;
        for (int i = 0; i < 6; i++) begin
            c = rand_cols();
            e = ref_sum(c);
            send_one(c, lat, p, p8);
            checks++;
            if (lat != LAT || p !== e || p8 !== e[15:8]) begin
                errors++;
                $display("FAIL random_single[%0d]: got lat %0d %h/%h expected lat %0d %h/%h",
                         i, lat, p, p8, LAT, e, e[15:8]);
            end
        end
    endtask

    task automatic test_stream();
        logic [15:0] q[$];
        logic [NC-1:0][H-1:0] c;
        logic [15:0] held;
        logic [15:0] e;
        logic [31:0] r;
        logic stall;
        logic exp_rdy;
        int sent, got, extra;
        sent = 0;
        got = 0;
        stall = 0;
        held = '0;
        c = '0;
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || product !== held) begin
                    errors++;
                    $display("FAIL stream_stall_hold: got %b %h expected 1 %h",
                             out_valid, product, held);
                end
            end
            if (sent < 20) begin
                c = rand_cols();
                in_cols = c;
                in_valid = 1'b1;
                r = $urandom;
                out_ready = r[0];
            end else begin
                in_valid = 1'b0;
                in_cols = 'x;
                out_ready = 1'b1;
            end
            #1;
            exp_rdy = (q.size() < LAT) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stream_in_ready: got %b expected %b (occupancy %0d)",
                         in_ready, exp_rdy, q.size());
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_output: got %h expected none", product);
                end else begin
                    e = q.pop_front();
                    if (product !== e) begin
                        errors++;
                        $display("FAIL stream_product[%0d]: got %h expected %h", got, product, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sum(c));
                sent++;
            end
            stall = out_valid && !out_ready;
            held = product;
        end
        checks++;
        if (sent != 20 || got != 20) begin
            errors++;
            $display("FAIL stream_count: got sent %0d received %0d expected 20/20", sent, got);
        end
        extra = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL stream_duplicate: got %0d extra outputs expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [NC-1:0][H-1:0] c;
        logic [15:0] e;
        int sent, got, first, last;
        sent = 0;
        got = 0;
        first = -1;
        last = -1;
        for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 12) begin
                c = rand_cols();
                in_cols = c;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_cols = 'x;
            end
            #1;
            if (out_valid) begin
                checks++;
                e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                if (product !== e) begin
                    errors++;
                    $display("FAIL b2b_product[%0d]: got %h expected %h", got, product, e);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
                end
                if (in_ready) begin
                    q.push_back(ref_sum(c));
                    sent++;
                end
            end
        end
        checks++;
        if (got != 12 || last - first != 11) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d items over %0d cycles expected 12 over 11",
                     got, last - first);
        end
        checks++;
        if (first != LAT) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected %0d", first, LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [NC-1:0][H-1:0] c;
        logic [15:0] p;
        logic [15:0] e;
        logic [7:0] p8;
        int acc, lat, stale;
        bit full;
        acc = 0;
        full = 0;
        for (int i = 0; i < 20 && !full; i++) begin
            @(negedge clk);
            in_cols = rand_cols();
            in_valid = 1'b1;
            out_ready = 1'b0;
            #1;
            if (!in_ready) full = 1;
            else acc++;
        end
        checks++;
        if (acc != LAT) begin
            errors++;
            $display("FAIL fill_occupancy: got %0d expected %0d", acc, LAT);
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || product !== 16'h0 || product8 !== 8'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b p=%h/%h rdy=%b expected 0 0/0 0",
                     out_valid, product, product8, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || out_valid8) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d outputs expected 0", stale);
        end
        c = rand_cols();
        e = ref_sum(c);
        send_one(c, lat, p, p8);
        checks++;
        if (lat != LAT || p !== e) begin
            errors++;
            $display("FAIL midreset_recover: got lat %0d %h expected lat %0d %h", lat, p, LAT, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stream();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
